mem_arbiter: RTL and testbench

- Shares the single-ported 64-bit data memory (mem) between the instruction-fetch port (read-only) and the data port (read/write) of the Y86-64 core.
- Serialises accesses with a round-robin grant and sequences mem's read/write strobes.
- Guarantees mem never sees read and write asserted together.
- Returns read data and the mem error flag to the winning requester with a one-cycle ack pulse.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the Y86-64 memory arbiter: word width, FSM state
// encoding, requester port identifiers and the default memory depth.
package mem_arb_pkg;

  localparam int unsigned WORD_W            = 64;
  localparam int unsigned MEM_WORDS_DEFAULT = 256;

  // Requester identifiers; also the bit positions in req/grant vectors.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // Arbiter FSM state encoding.
  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] ACCESS_ENC = 2'd1;
  localparam logic [1:0] RESP_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE_ENC,
    ST_ACCESS = ACCESS_ENC,
    ST_RESP   = RESP_ENC
  } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone requester always wins; when both
// request, the registered pointer names the winner. On every advance the
// pointer moves to the port that did not win, so contention alternates.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Select the winner from the live requests and the pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (ptr_q == PORT_DATA) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[PORT_FETCH] ? PORT_DATA : PORT_FETCH;
    end
  end

  // Pointer register; starts on the data port out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr_q <= PORT_DATA;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Memory arbiter for the Y86-64 core. Shares one single-ported 64-bit data
// memory between the read-only fetch port and the read/write data port.
// Each access runs IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP, with all
// outputs registered, so mem never sees read and write together and the
// winner receives a one-cycle ack carrying read data and the mem error.
//
// Optional feature, enabled by defining MEM_ARB_ADDR_CHECK_EN: a granted
// address >= MEM_WORDS skips ACCESS and is answered with err=1, rdata=0 in
// the cycle after the grant, without touching mem.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
`ifdef MEM_ARB_ADDR_CHECK_EN
  , parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch port (read-only)
  input  logic              f_req,
  input  logic [WORD_W-1:0] f_addr,
  output logic              f_ack,
  output logic [WORD_W-1:0] f_rdata,
  output logic              f_err,
  // Data port (read/write)
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  // Memory side
  output logic              mem_write,
  output logic              mem_read,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_error,
  input  logic [WORD_W-1:0] mem_rdata,
  // Status
  output logic              busy
);

  // Counter value on the last ACCESS cycle.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  arb_state_e        state_q;
  logic [3:0]        lat_cnt_q;
  logic              port_q;
  logic              we_q;

  logic              f_ack_q;
  logic [WORD_W-1:0] f_rdata_q;
  logic              f_err_q;
  logic              d_ack_q;
  logic [WORD_W-1:0] d_rdata_q;
  logic              d_err_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              busy_q;

  // Grant selection: requests are only considered while idle.
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              advance;
  logic              sel_port;
  logic              sel_we;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic              sel_bad;

  assign req[PORT_FETCH] = f_req;
  assign req[PORT_DATA]  = d_req;
  assign advance         = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (advance),
    .grant_o   (grant)
  );

  // Operands of the winning port; fetch is always a read with no write data.
  assign sel_port  = grant[PORT_DATA] ? PORT_DATA : PORT_FETCH;
  assign sel_we    = grant[PORT_DATA] & d_we;
  assign sel_addr  = grant[PORT_DATA] ? d_addr : f_addr;
  assign sel_wdata = grant[PORT_DATA] ? d_wdata : '0;

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign sel_bad = (sel_addr >= WORD_W'(MEM_WORDS));
`else
  assign sel_bad = 1'b0;
`endif

  // Arbiter FSM: latches the grant, sequences the strobes and returns the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      port_q      <= PORT_FETCH;
      we_q        <= 1'b0;
      f_ack_q     <= 1'b0;
      f_rdata_q   <= '0;
      f_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (advance) begin
            port_q    <= sel_port;
            we_q      <= sel_we;
            lat_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (sel_bad) begin
              // Out-of-range address: answer directly, mem is never strobed.
              state_q <= ST_RESP;
              if (sel_port == PORT_DATA) begin
                d_ack_q   <= 1'b1;
                d_rdata_q <= '0;
                d_err_q   <= 1'b1;
              end else begin
                f_ack_q   <= 1'b1;
                f_rdata_q <= '0;
                f_err_q   <= 1'b1;
              end
            end else begin
              state_q     <= ST_ACCESS;
              mem_read_q  <= ~sel_we;
              mem_write_q <= sel_we;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end
          end
        end

        ST_ACCESS: begin
          if (lat_cnt_q == LAT_LAST) begin
            // Last strobe cycle: sample mem and drop everything toward it.
            state_q     <= ST_RESP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (port_q == PORT_DATA) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= we_q ? '0 : mem_rdata;
              d_err_q   <= mem_error;
            end else begin
              f_ack_q   <= 1'b1;
              f_rdata_q <= mem_rdata;
              f_err_q   <= mem_error;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
          end
        end

        ST_RESP: begin
          // Ack has been shown for one cycle; clear the response and go idle.
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          f_ack_q   <= 1'b0;
          f_rdata_q <= '0;
          f_err_q   <= 1'b0;
          d_ack_q   <= 1'b0;
          d_rdata_q <= '0;
          d_err_q   <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign f_ack     = f_ack_q;
  assign f_rdata   = f_rdata_q;
  assign f_err     = f_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Instance u_dut (MEM_LATENCY=1) sits on a
// small behavioural memory; instance u_lat3 (MEM_LATENCY=3) has its memory
// response driven step by step to show exactly when data is sampled.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance with MEM_LATENCY = 1
  logic        f_req, f_ack, f_err;
  logic [63:0] f_addr, f_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        mem_write, mem_read, mem_error, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  // Instance with MEM_LATENCY = 3
  logic        b_f_req, b_f_ack, b_f_err;
  logic [63:0] b_f_addr, b_f_rdata;
  logic        b_d_req, b_d_we, b_d_ack, b_d_err;
  logic [63:0] b_d_addr, b_d_wdata, b_d_rdata;
  logic        b_mem_write, b_mem_read, b_mem_error, b_busy;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.MEM_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_error(mem_error), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_ack(b_f_ack), .f_rdata(b_f_rdata), .f_err(b_f_err),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .d_err(b_d_err),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_error(b_mem_error), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  // Behavioural 256-word memory: combinational read, write on the clock edge,
  // error for any strobed address outside the array.
  logic [63:0] mem_model [0:255];

  always @(posedge clk) begin
    if (mem_write && (mem_addr < 64'd256)) mem_model[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata = (mem_read && (mem_addr < 64'd256)) ? mem_model[mem_addr[7:0]] : 64'd0;
  assign mem_error = (mem_read || mem_write) && (mem_addr >= 64'd256);

  // Invariant watchers over both instances, evaluated mid-cycle.
  int overlap_cnt  = 0;
  int dual_ack_cnt = 0;

  always @(negedge clk) begin
    if ((mem_read && mem_write) || (b_mem_read && b_mem_write)) overlap_cnt++;
    if ((f_ack && d_ack) || (b_f_ack && b_d_ack)) dual_ack_cnt++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    f_req   = 1'b0; f_addr  = '0;
    d_req   = 1'b0; d_we    = 1'b0; d_addr = '0; d_wdata = '0;
    b_f_req = 1'b0; b_f_addr = '0;
    b_d_req = 1'b0; b_d_we  = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    b_mem_rdata = '0; b_mem_error = 1'b0;

    // ---- Reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_mem_read",  64'(mem_read),  64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_addr",  mem_addr,       64'd0);
    check("rst_acks",      64'({f_ack, d_ack}), 64'd0);
    check("rst_b_busy",    64'(b_busy),    64'd0);
    @(negedge clk) rst_n = 1'b1;

    // ---- Data write 12 to 217 ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd217; d_wdata = 64'd12;
    check("wr_c0_busy", 64'(busy), 64'd0);
    tick();
    check("wr_c1_mem_write", 64'(mem_write), 64'd1);
    check("wr_c1_mem_read",  64'(mem_read),  64'd0);
    check("wr_c1_mem_addr",  mem_addr,       64'd217);
    check("wr_c1_mem_wdata", mem_wdata,      64'd12);
    check("wr_c1_d_ack",     64'(d_ack),     64'd0);
    tick();
    check("wr_c2_d_ack",     64'(d_ack),     64'd1);
    check("wr_c2_d_err",     64'(d_err),     64'd0);
    check("wr_c2_d_rdata",   d_rdata,        64'd0);
    check("wr_c2_mem_write", 64'(mem_write), 64'd0);
    check("wr_c2_f_ack",     64'(f_ack),     64'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check("wr_c3_d_ack", 64'(d_ack), 64'd0);
    check("wr_c3_busy",  64'(busy),  64'd0);

    // ---- Fetch read of 217 ----
    f_req = 1'b1; f_addr = 64'd217;
    tick();
    check("rd_c1_mem_read", 64'(mem_read), 64'd1);
    check("rd_c1_mem_addr", mem_addr,      64'd217);
    tick();
    check("rd_c2_f_ack",   64'(f_ack), 64'd1);
    check("rd_c2_f_rdata", f_rdata,    64'd12);
    check("rd_c2_f_err",   64'(f_err), 64'd0);
    check("rd_c2_d_ack",   64'(d_ack), 64'd0);
    f_req = 1'b0;
    tick();

    // ---- Data read of out-of-range address 256 ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd256;
    tick();
`ifdef MEM_ARB_ADDR_CHECK_EN
    check("bad_c1_d_ack",    64'(d_ack),    64'd1);
    check("bad_c1_d_err",    64'(d_err),    64'd1);
    check("bad_c1_d_rdata",  d_rdata,       64'd0);
    check("bad_c1_mem_read", 64'(mem_read), 64'd0);
    d_req = 1'b0;
    tick();
    check("bad_c2_d_ack",    64'(d_ack),    64'd0);
    check("bad_c2_mem_read", 64'(mem_read), 64'd0);
`else
    check("bad_c1_mem_read", 64'(mem_read), 64'd1);
    check("bad_c1_mem_addr", mem_addr,      64'd256);
    check("bad_c1_d_ack",    64'(d_ack),    64'd0);
    tick();
    check("bad_c2_d_ack",    64'(d_ack),    64'd1);
    check("bad_c2_d_err",    64'(d_err),    64'd1);
    check("bad_c2_d_rdata",  d_rdata,       64'd0);
    check("bad_c2_mem_read", 64'(mem_read), 64'd0);
    d_req = 1'b0;
    tick();
`endif
    check("bad_idle_busy", 64'(busy), 64'd0);

    // ---- Contention straight out of reset: data, fetch, data ----
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    f_req = 1'b1; f_addr = 64'd217;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'd20; d_wdata = 64'h55;
    tick();
    check("ct_c1_mem_write", 64'(mem_write), 64'd1);
    check("ct_c1_mem_read",  64'(mem_read),  64'd0);
    check("ct_c1_mem_addr",  mem_addr,       64'd20);
    tick();
    check("ct_c2_acks", 64'({f_ack, d_ack}), 64'b01);
    check("ct_c2_d_err", 64'(d_err), 64'd0);
    tick();
    check("ct_c3_busy", 64'(busy), 64'd0);
    tick();
    check("ct_c4_mem_read",  64'(mem_read),  64'd1);
    check("ct_c4_mem_write", 64'(mem_write), 64'd0);
    check("ct_c4_mem_addr",  mem_addr,       64'd217);
    tick();
    check("ct_c5_acks",    64'({f_ack, d_ack}), 64'b10);
    check("ct_c5_f_rdata", f_rdata,             64'd12);
    tick();
    tick();
    check("ct_c7_mem_write", 64'(mem_write), 64'd1);
    check("ct_c7_mem_wdata", mem_wdata,      64'h55);
    tick();
    check("ct_c8_acks", 64'({f_ack, d_ack}), 64'b01);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();

    // ---- Reset in the middle of an access ----
    f_req = 1'b1; f_addr = 64'd20;
    tick();
    check("ra_c1_mem_read", 64'(mem_read), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ra_in_mem_read", 64'(mem_read), 64'd0);
    check("ra_in_busy",     64'(busy),     64'd0);
    check("ra_in_mem_addr", mem_addr,      64'd0);
    tick();
    check("ra_held_f_ack",  64'(f_ack),    64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("ra_c1_mem_read_again", 64'(mem_read), 64'd1);
    check("ra_c1_mem_addr",       mem_addr,      64'd20);
    tick();
    check("ra_c2_f_ack",   64'(f_ack), 64'd1);
    check("ra_c2_f_rdata", f_rdata,    64'h55);
    // f_req stays high past the ack: it must start a fresh access.
    tick();
    check("ra_c3_f_ack", 64'(f_ack), 64'd0);
    check("ra_c3_busy",  64'(busy),  64'd0);
    tick();
    check("ra_c4_mem_read", 64'(mem_read), 64'd1);
    f_req = 1'b0;
    tick();
    check("ra_c5_f_ack", 64'(f_ack), 64'd1);
    tick();

    // ---- MEM_LATENCY = 3: data read of address 5, req dropped after cycle 1 ----
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 64'd5;
    check("l3_c0_busy", 64'(b_busy), 64'd0);
    tick();
    check("l3_c1_mem_read",  64'(b_mem_read),  64'd1);
    check("l3_c1_mem_write", 64'(b_mem_write), 64'd0);
    check("l3_c1_mem_addr",  b_mem_addr,       64'd5);
    check("l3_c1_mem_wdata", b_mem_wdata,      64'd0);
    b_d_req = 1'b0;
    b_mem_rdata = 64'd1;
    tick();
    check("l3_c2_mem_read", 64'(b_mem_read), 64'd1);
    check("l3_c2_d_ack",    64'(b_d_ack),    64'd0);
    b_mem_rdata = 64'd2;
    tick();
    check("l3_c3_mem_read", 64'(b_mem_read), 64'd1);
    check("l3_c3_d_ack",    64'(b_d_ack),    64'd0);
    b_mem_rdata = 64'h5A5A; b_mem_error = 1'b1;
    tick();
    check("l3_c4_mem_read", 64'(b_mem_read), 64'd0);
    check("l3_c4_d_ack",    64'(b_d_ack),    64'd1);
    check("l3_c4_d_rdata",  b_d_rdata,       64'h5A5A);
    check("l3_c4_d_err",    64'(b_d_err),    64'd1);
    check("l3_c4_f_side",   64'({b_f_ack, b_f_err}) | b_f_rdata, 64'd0);
    b_mem_rdata = '0; b_mem_error = 1'b0;
    tick();
    check("l3_c5_d_ack", 64'(b_d_ack), 64'd0);
    check("l3_c5_busy",  64'(b_busy),  64'd0);

    // ---- Invariants observed over the whole run ----
    check("inv_read_write_overlap", 64'(overlap_cnt),  64'd0);
    check("inv_dual_ack",           64'(dual_ack_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
